// File: rtl/uc_pkg.sv
// Shared encodings for the gen-2 sequencer: opcodes, SYS subcodes, FSM states.
package uc_pkg;

    localparam logic [3:0] OP_SYS   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BC    = 4'h5;
    localparam logic [3:0] OP_IN    = 4'h6;
    localparam logic [3:0] OP_OUT   = 4'h7;

    localparam logic [3:0] SYS_NOP  = 4'h0;
    localparam logic [3:0] SYS_CALL = 4'h1;
    localparam logic [3:0] SYS_RET  = 4'h2;
    localparam logic [3:0] SYS_HALT = 4'h3;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXECUTE  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

endpackage

// File: rtl/uc_call_stack.sv
// Return-address LIFO. The caller never pushes when full nor pops when empty;
// r_sp counts occupied entries, so the top of stack is entry r_sp-1.
module uc_call_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] r_mem [DEPTH];
    logic [SPW-1:0]  r_sp;
    logic [PC_W-1:0] w_top;

    // Storage and pointer update; writes land in the slot just above the top.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (r_sp == SPW'(i)) r_mem[i] <= push_data;
            r_sp <= r_sp + 1'b1;
        end else if (pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Top-of-stack select without a narrowing index into r_mem.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_sp == SPW'(i + 1)) w_top = r_mem[i];
    end

    assign top   = w_top;
    assign full  = (r_sp == SPW'(DEPTH));
    assign empty = (r_sp == '0);

endmodule

// File: rtl/control_unit_v2.sv
// Gen-2 microcontroller sequencer: FETCH latches the instruction and ALU operands,
// EXECUTE performs the op and registers every side effect, so strobes such as
// pc_load and out_valid appear for exactly one cycle after EXECUTE.
// SRAM handshake: sram_req (with we/addr/data) rises on entry to MEM_WAIT and stays
// stable until a cycle in MEM_WAIT sees sram_ready high; that edge completes the
// access and drops sram_req. sram_ready is never looked at outside MEM_WAIT.
module control_unit_v2 #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4,
    parameter int N_OUT       = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [15:0]             instruction,
    input  logic [PC_W-1:0]         pc_value,
    input  logic [DATA_W-1:0]       sram_read_data,
    input  logic                    sram_ready,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    equal,
    input  logic                    carry_out,
    input  logic [DATA_W-1:0]       in_gpio,
    input  logic                    bootstrapping,
    output logic [2:0]              alu_opcode,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic                    sram_req,
    output logic                    sram_write_en,
    output logic [7:0]              sram_addr,
    output logic [DATA_W-1:0]       sram_write_data,
    output logic                    pc_load,
    output logic [PC_W-1:0]         pc_next,
    output logic                    pc_inc,
    output logic [N_OUT*DATA_W-1:0] out_gpio,
    output logic [N_OUT-1:0]        out_valid,
    output logic [1:0]              state,
    output logic                    stack_err
);

    import uc_pkg::*;

    state_t                    r_state, w_state_nxt;
    logic [3:0]                r_op, r_dst, r_a, r_b;
    logic [DATA_W-1:0]         r_regs [16];
    logic [2:0]                r_alu_opcode;
    logic [DATA_W-1:0]         r_alu_a, r_alu_b;
    logic                      r_sram_req, r_sram_we;
    logic [7:0]                r_sram_addr;
    logic [DATA_W-1:0]         r_sram_wdata;
    logic                      r_pc_load;
    logic [PC_W-1:0]           r_pc_next;
    logic [N_OUT*DATA_W-1:0]   r_out_gpio;
    logic [N_OUT-1:0]          r_out_valid;
    logic                      r_stack_err;
    logic                      w_push, w_pop, w_stack_fault;
    logic                      w_full, w_empty;
    logic [PC_W-1:0]           w_top;

    uc_call_stack #(.PC_W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc_value),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= ST_FETCH;
        else         r_state <= w_state_nxt;
    end

    // Next state plus stack control; a stack fault parks the sequencer in HALT.
    always_comb begin
        w_state_nxt   = r_state;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_stack_fault = 1'b0;
        case (r_state)
            ST_FETCH:   w_state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                w_state_nxt = ST_FETCH;
                case (r_op)
                    OP_SYS: begin
                        case (r_dst)
                            SYS_CALL: begin
                                if (w_full) begin
                                    w_stack_fault = 1'b1;
                                    w_state_nxt   = ST_HALT;
                                end else begin
                                    w_push = 1'b1;
                                end
                            end
                            SYS_RET: begin
                                if (w_empty) begin
                                    w_stack_fault = 1'b1;
                                    w_state_nxt   = ST_HALT;
                                end else begin
                                    w_pop = 1'b1;
                                end
                            end
                            SYS_HALT: w_state_nxt = ST_HALT;
                            default:  ;
                        endcase
                    end
                    OP_LOAD, OP_STORE: w_state_nxt = ST_MEM_WAIT;
                    default: ;
                endcase
            end
            ST_MEM_WAIT: if (sram_ready) w_state_nxt = ST_FETCH;
            default:     w_state_nxt = ST_HALT;
        endcase
    end

    // Datapath: operand latch, register file writes and all registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_op <= '0; r_dst <= '0; r_a <= '0; r_b <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
            r_alu_opcode <= '0; r_alu_a <= '0; r_alu_b <= '0;
            r_sram_req <= 1'b0; r_sram_we <= 1'b0;
            r_sram_addr <= '0; r_sram_wdata <= '0;
            r_pc_load <= 1'b0; r_pc_next <= '0;
            r_out_gpio <= '0; r_out_valid <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_pc_load   <= 1'b0;
            r_out_valid <= '0;
            case (r_state)
                ST_FETCH: begin
                    r_op         <= instruction[15:12];
                    r_dst        <= instruction[11:8];
                    r_a          <= instruction[7:4];
                    r_b          <= instruction[3:0];
                    r_alu_opcode <= instruction[14:12];
                    r_alu_a      <= r_regs[instruction[7:4]];
                    r_alu_b      <= r_regs[instruction[3:0]];
                end
                ST_EXECUTE: begin
                    case (r_op)
                        OP_SYS: begin
                            if (w_push) begin
                                r_pc_next <= PC_W'({r_a, r_b});
                                r_pc_load <= 1'b1;
                            end
                            if (w_pop) begin
                                r_pc_next <= w_top;
                                r_pc_load <= 1'b1;
                            end
                            if (w_stack_fault) r_stack_err <= 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            r_sram_req   <= 1'b1;
                            r_sram_we    <= (r_op == OP_STORE);
                            r_sram_addr  <= {r_a, r_b};
                            r_sram_wdata <= r_regs[r_dst];
                        end
                        OP_JMP: begin
                            r_pc_next <= PC_W'({r_dst, r_a, r_b});
                            r_pc_load <= 1'b1;
                        end
                        OP_BEQ, OP_BC: begin
                            if ((r_op == OP_BEQ) ? equal : carry_out) begin
                                r_pc_next <= PC_W'({r_dst, r_a, r_b});
                                r_pc_load <= 1'b1;
                            end
                        end
                        OP_IN: r_regs[r_dst] <= bootstrapping ? DATA_W'({r_a, r_b}) : in_gpio;
                        OP_OUT: begin
                            for (int k = 0; k < N_OUT; k++) begin
                                if (r_b == 4'(k)) begin
                                    r_out_gpio[k*DATA_W +: DATA_W] <= r_regs[r_dst];
                                    r_out_valid[k]                 <= 1'b1;
                                end
                            end
                        end
                        default: r_regs[r_dst] <= alu_result;
                    endcase
                end
                ST_MEM_WAIT: begin
                    if (sram_ready) begin
                        r_sram_req <= 1'b0;
                        r_sram_we  <= 1'b0;
                        if (r_op == OP_LOAD) r_regs[r_dst] <= sram_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_opcode      = r_alu_opcode;
    assign alu_a           = r_alu_a;
    assign alu_b           = r_alu_b;
    assign sram_req        = r_sram_req;
    assign sram_write_en   = r_sram_we;
    assign sram_addr       = r_sram_addr;
    assign sram_write_data = r_sram_wdata;
    assign pc_load         = r_pc_load;
    assign pc_next         = r_pc_next;
    assign pc_inc          = (r_state == ST_FETCH);
    assign out_gpio        = r_out_gpio;
    assign out_valid       = r_out_valid;
    assign state           = r_state;
    assign stack_err       = r_stack_err;

endmodule
